// File: rtl/dram_word_writer.sv
// ---------------------------------------------------------------------------
// dram_word_writer
//
// Purpose:
//   Sits behind the 272-bit variable-length packer. It follows the same
//   len/ce beat stream as the packer to know how many bits have built up.
//   Once a full word is present it captures the packer output register. The
//   captured words go into a 2-entry FIFO. Each word is presented to the DRAM
//   write port with an incrementing word address over a valid/ready
//   handshake.
//
// Ports:
//   clk        in   rising-edge clock shared with the packer
//   rst_n      in   asynchronous active-low reset
//   ce         in   a packer beat occurs this cycle
//   len        in   bits in this beat (legal: 16, 32, 48, 64)
//   pack_data  in   packer output register (valid one cycle after the beat)
//   wr_data    out  word presented to DRAM (FIFO head, registered)
//   wr_addr    out  word address of wr_data (FIFO head, registered)
//   wr_valid   out  wr_data/wr_addr are valid
//   wr_ready   in   DRAM accepts the word when wr_valid & wr_ready
//   fill       out  bits accumulated toward the next word
//   overflow   out  sticky: a captured word was dropped
//   len_err    out  sticky: ce was asserted with an illegal len
//
// Optional feature (macro DRAM_WR_DROP_CNT_EN):
//   drop_cnt   out  saturating 16-bit count of dropped words
// ---------------------------------------------------------------------------
module dram_word_writer #(
    parameter int WIDTH      = 272,
    parameter int BIT_LEN    = 9,
    parameter int ADDR_W     = 16,
    parameter int ADDR_DEPTH = 65536
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ce,
    input  logic [BIT_LEN-1:0]  len,
    input  logic [WIDTH-1:0]    pack_data,
    output logic [WIDTH-1:0]    wr_data,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic                wr_valid,
    input  logic                wr_ready,
    output logic [BIT_LEN-1:0]  fill,
    output logic                overflow,
    output logic                len_err
`ifdef DRAM_WR_DROP_CNT_EN
    ,
    output logic [15:0]         drop_cnt
`endif
);

    localparam logic [BIT_LEN:0]  WIDTH_EXT = (BIT_LEN+1)'(WIDTH);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(ADDR_DEPTH - 1);

    logic                capture_pend;
    logic [ADDR_W-1:0]   addr_cnt;

    // Second FIFO slot; the first slot is the registered head on the ports.
    logic [WIDTH-1:0]    tail_data;
    logic [ADDR_W-1:0]   tail_addr;
    logic                tail_valid;

    logic                len_legal;
    logic [BIT_LEN:0]    sum;
    logic                pop;
    logic                drop;

    always_comb begin
        len_legal = (len == BIT_LEN'(16)) || (len == BIT_LEN'(32)) ||
                    (len == BIT_LEN'(48)) || (len == BIT_LEN'(64));
        sum       = {1'b0, fill} + {1'b0, len};
        pop       = wr_valid & wr_ready;
        // Full means both slots occupied; a pop on the same edge frees one.
        drop      = capture_pend & wr_valid & tail_valid & ~pop;
    end

    // Beat accounting: mirror the packer's fill level. The capture flag is
    // set on the beat that completes a word, because the packer register only
    // shows that word one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill         <= '0;
            capture_pend <= 1'b0;
            len_err      <= 1'b0;
        end else if (ce) begin
            if (len_legal) begin
                if (sum >= WIDTH_EXT) begin
                    fill         <= BIT_LEN'(sum - WIDTH_EXT);
                    capture_pend <= 1'b1;
                end else begin
                    fill         <= sum[BIT_LEN-1:0];
                    capture_pend <= 1'b0;
                end
            end else begin
                capture_pend <= 1'b0;
                len_err      <= 1'b1;
            end
        end else begin
            capture_pend <= 1'b0;
        end
    end

    // Every captured word uses up an address, including dropped ones. This
    // keeps later DRAM addresses aligned with the data stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_cnt <= '0;
        end else if (capture_pend) begin
            addr_cnt <= (addr_cnt == ADDR_LAST) ? '0 : addr_cnt + 1'b1;
        end
    end

    // Two-slot FIFO. The head slot drives the ports directly. On a pop, the
    // tail moves into the head and any new capture refills the tail.
    // wr_data holds its last value while the FIFO is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_data    <= '0;
            wr_addr    <= '0;
            wr_valid   <= 1'b0;
            tail_data  <= '0;
            tail_addr  <= '0;
            tail_valid <= 1'b0;
        end else if (pop) begin
            if (tail_valid) begin
                wr_data <= tail_data;
                wr_addr <= tail_addr;
                if (capture_pend) begin
                    tail_data <= pack_data;
                    tail_addr <= addr_cnt;
                end else begin
                    tail_valid <= 1'b0;
                end
            end else if (capture_pend) begin
                wr_data <= pack_data;
                wr_addr <= addr_cnt;
            end else begin
                wr_valid <= 1'b0;
            end
        end else if (capture_pend) begin
            if (!wr_valid) begin
                wr_data  <= pack_data;
                wr_addr  <= addr_cnt;
                wr_valid <= 1'b1;
            end else if (!tail_valid) begin
                tail_data  <= pack_data;
                tail_addr  <= addr_cnt;
                tail_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

`ifdef DRAM_WR_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dram_word_writer.sv
// ---------------------------------------------------------------------------
// tb_dram_word_writer
//
// Drives two writers from the same beat stream: one with the default
// address range and one with ADDR_DEPTH=4. Both are compared every cycle
// against a queue-based model of the word stream. A few hand-worked
// scenarios pin the model with literal values.
// ---------------------------------------------------------------------------
module tb_dram_word_writer;

    localparam int WIDTH = 272;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ce = 1'b0;
    logic [8:0]        len = '0;
    logic [WIDTH-1:0]  packData = '0;
    logic              wrReady = 1'b0;

    logic [WIDTH-1:0]  wrData, wrData4;
    logic [15:0]       wrAddr, wrAddr4;
    logic              wrValid, wrValid4;
    logic [8:0]        fill, fill4;
    logic              overflow, overflow4;
    logic              lenErr, lenErr4;
`ifdef DRAM_WR_DROP_CNT_EN
    logic [15:0]       dropCnt, dropCnt4;
`endif

    int testsRun = 0;
    int testsFailed = 0;
    bit checkEn = 1'b0;
    bit collect4 = 1'b0;
    int seq4[$];

    dram_word_writer dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .len(len), .pack_data(packData),
        .wr_data(wrData), .wr_addr(wrAddr), .wr_valid(wrValid),
        .wr_ready(wrReady), .fill(fill), .overflow(overflow), .len_err(lenErr)
`ifdef DRAM_WR_DROP_CNT_EN
        , .drop_cnt(dropCnt)
`endif
    );

    dram_word_writer #(.ADDR_DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .len(len), .pack_data(packData),
        .wr_data(wrData4), .wr_addr(wrAddr4), .wr_valid(wrValid4),
        .wr_ready(wrReady), .fill(fill4), .overflow(overflow4), .len_err(lenErr4)
`ifdef DRAM_WR_DROP_CNT_EN
        , .drop_cnt(dropCnt4)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural model: bit count, pending-capture flag, word queue.
    typedef struct {
        logic [WIDTH-1:0] data;
        int               addr;
    } entry_t;

    entry_t           q[$];
    int               mFill;
    bit               mPend;
    int               mAddr;
    bit               mOvf;
    bit               mLenErr;
    int               mDrop;
    logic [WIDTH-1:0] mLastData;

    task automatic modelReset();
        q.delete();
        mFill = 0; mPend = 0; mAddr = 0; mOvf = 0; mLenErr = 0; mDrop = 0;
        mLastData = '0;
    endtask

    task automatic modelStep();
        int s;
        if (q.size() > 0 && wrReady) void'(q.pop_front());
        if (mPend) begin
            if (q.size() < 2) q.push_back('{packData, mAddr});
            else begin
                mOvf = 1;
                if (mDrop < 65535) mDrop++;
            end
            mAddr++;
        end
        mPend = 0;
        if (ce) begin
            if (len inside {9'd16, 9'd32, 9'd48, 9'd64}) begin
                s = mFill + int'(len);
                if (s >= WIDTH) begin
                    mFill = s - WIDTH;
                    mPend = 1;
                end else begin
                    mFill = s;
                end
            end else begin
                mLenErr = 1;
            end
        end
        if (q.size() > 0) mLastData = q[0].data;
    endtask

    initial begin
        modelReset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) modelReset();
            else modelStep();
        end
    end

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                               input logic [WIDTH-1:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && checkEn) begin
                logic [WIDTH-1:0] expData;
                bit expValid;
                expValid = (q.size() > 0);
                expData  = expValid ? q[0].data : mLastData;
                checkOutput("wr_valid", WIDTH'(wrValid), WIDTH'(expValid));
                checkOutput("wr_data", wrData, expData);
                checkOutput("fill", WIDTH'(fill), WIDTH'(mFill));
                checkOutput("overflow", WIDTH'(overflow), WIDTH'(mOvf));
                checkOutput("len_err", WIDTH'(lenErr), WIDTH'(mLenErr));
                checkOutput("wr_valid4", WIDTH'(wrValid4), WIDTH'(expValid));
                checkOutput("wr_data4", wrData4, expData);
                if (expValid) begin
                    checkOutput("wr_addr", WIDTH'(wrAddr), WIDTH'(q[0].addr % 65536));
                    checkOutput("wr_addr4", WIDTH'(wrAddr4), WIDTH'(q[0].addr % 4));
                end
`ifdef DRAM_WR_DROP_CNT_EN
                checkOutput("drop_cnt", WIDTH'(dropCnt), WIDTH'(mDrop));
`endif
                if (collect4 && wrValid4) seq4.push_back(int'(wrAddr4));
            end
        end
    end

    function automatic logic [WIDTH-1:0] randWord();
        logic [287:0] t;
        for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom();
        return t[WIDTH-1:0];
    endfunction

    // Drive one cycle of inputs just after a falling edge and return at the
    // next falling edge, after the rising edge has consumed them.
    task automatic applyStimulus(input bit c, input int l, input bit r);
        #1;
        ce       = c;
        len      = 9'(l);
        wrReady  = r;
        packData = randWord();
        @(negedge clk);
    endtask

    task automatic doReset();
        #1;
        rst_n = 1'b0;
        ce = 1'b0;
        wrReady = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    logic [WIDTH-1:0] capPack;

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // Reset state
        @(negedge clk);
        checkOutput("rst_wr_valid", WIDTH'(wrValid), '0);
        checkOutput("rst_wr_data", wrData, '0);
        checkOutput("rst_wr_addr", WIDTH'(wrAddr), '0);
        checkOutput("rst_fill", WIDTH'(fill), '0);
        checkOutput("rst_flags", WIDTH'({overflow, lenErr}), '0);
        #1 rst_n = 1'b1;
        checkEn = 1'b1;

        // 17 beats of 16 bits complete exactly one word
        for (int k = 1; k <= 16; k++) applyStimulus(1, 16, 1);
        checkOutput("t1_fill_256", WIDTH'(fill), WIDTH'(256));
        applyStimulus(1, 16, 1);
        checkOutput("t1_fill_0", WIDTH'(fill), '0);
        applyStimulus(0, 0, 1);
        capPack = packData;
        checkOutput("t1_valid", WIDTH'(wrValid), WIDTH'(1));
        checkOutput("t1_addr", WIDTH'(wrAddr), '0);
        checkOutput("t1_data", wrData, capPack);
        applyStimulus(0, 0, 1);
        checkOutput("t1_valid_off", WIDTH'(wrValid), '0);
        checkOutput("t1_data_hold", wrData, capPack);

        // len=64 stream: word after beat 5 leaves 48, next word at beat 9
        doReset();
        for (int k = 1; k <= 5; k++) applyStimulus(1, 64, 1);
        checkOutput("t2_fill_48", WIDTH'(fill), WIDTH'(48));
        for (int k = 6; k <= 9; k++) applyStimulus(1, 64, 1);
        checkOutput("t2_fill_32", WIDTH'(fill), WIDTH'(32));
        applyStimulus(0, 0, 1);
        checkOutput("t2_addr_1", WIDTH'(wrAddr), WIDTH'(1));

        // Back-pressure: third word dropped, address still advances
        doReset();
        for (int k = 1; k <= 13; k++) applyStimulus(1, 64, 0);
        applyStimulus(0, 0, 0);
        checkOutput("t3_overflow", WIDTH'(overflow), WIDTH'(1));
        checkOutput("t3_hold_addr0", WIDTH'(wrAddr), '0);
`ifdef DRAM_WR_DROP_CNT_EN
        checkOutput("t3_drop_cnt", WIDTH'(dropCnt), WIDTH'(1));
`endif
        applyStimulus(0, 0, 1);
        checkOutput("t3_drain_addr1", WIDTH'(wrAddr), WIDTH'(1));
        applyStimulus(0, 0, 1);
        checkOutput("t3_empty", WIDTH'(wrValid), '0);
        for (int k = 14; k <= 17; k++) applyStimulus(1, 64, 1);
        applyStimulus(0, 0, 1);
        checkOutput("t3_addr3", WIDTH'(wrAddr), WIDTH'(3));

        // Illegal length mid-stream
        doReset();
        applyStimulus(1, 16, 1);
        applyStimulus(1, 16, 1);
        applyStimulus(1, 40, 1);
        checkOutput("t4_len_err", WIDTH'(lenErr), WIDTH'(1));
        checkOutput("t4_fill_kept", WIDTH'(fill), WIDTH'(32));
        applyStimulus(1, 16, 1);
        checkOutput("t4_fill_48", WIDTH'(fill), WIDTH'(48));

        // Address wrap on the ADDR_DEPTH=4 instance
        doReset();
        seq4.delete();
        collect4 = 1'b1;
        for (int k = 1; k <= 22; k++) applyStimulus(1, 64, 1);
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 1);
        collect4 = 1'b0;
        checkOutput("t5_count", WIDTH'(seq4.size()), WIDTH'(5));
        if (seq4.size() == 5) begin
            checkOutput("t5_seq0", WIDTH'(seq4[0]), WIDTH'(0));
            checkOutput("t5_seq3", WIDTH'(seq4[3]), WIDTH'(3));
            checkOutput("t5_seq4", WIDTH'(seq4[4]), WIDTH'(0));
        end

        // Asynchronous reset with two buffered words and fill=128
        doReset();
        for (int k = 1; k <= 9; k++) applyStimulus(1, 64, 0);
        applyStimulus(1, 48, 0);
        applyStimulus(1, 48, 0);
        applyStimulus(1, 40, 0);
        checkOutput("t6_fill_128", WIDTH'(fill), WIDTH'(128));
        checkOutput("t6_valid", WIDTH'(wrValid), WIDTH'(1));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_async_valid", WIDTH'(wrValid), '0);
        checkOutput("t6_async_fill", WIDTH'(fill), '0);
        checkOutput("t6_async_flags", WIDTH'({overflow, lenErr}), '0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (int k = 1; k <= 17; k++) applyStimulus(1, 16, 1);
        applyStimulus(0, 0, 1);
        checkOutput("t6_first_addr", WIDTH'(wrAddr), '0);
        checkOutput("t6_first_valid", WIDTH'(wrValid), WIDTH'(1));

        // Randomized traffic, with one asynchronous reset in the middle
        doReset();
        for (int i = 0; i < 3000; i++) begin
            int l;
            if ($urandom_range(0, 19) == 0) l = int'($urandom_range(0, 511));
            else l = 16 * int'($urandom_range(1, 4));
            applyStimulus($urandom_range(0, 9) < 7, l, $urandom_range(0, 1) == 1);
            if (i == 1500) doReset();
        end

        checkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/dram_word_writer.md
Name: dram_word_writer

Overview:
- Sits directly downstream of the 272-bit variable-length packer.
- Tracks how many bits the packer has accumulated from the same len/ce stream, and captures the packer's 272-bit output once a full word is present.
- Buffers captured words in a 2-entry FIFO and presents each with an incrementing word address to the DRAM write port over a valid/ready handshake.

Parameters:
- WIDTH, 272, packed word width in bits; must be a multiple of 16.
- BIT_LEN, 9, width of len and of the fill counter.
- ADDR_W, 16, width of the DRAM word address.
- ADDR_DEPTH, 65536, number of word addresses; the address wraps to 0 after ADDR_DEPTH-1.

Ports:
- clk  in  1  rising-edge clock shared with the packer.
- rst_n  in  1  asynchronous, active-low reset.
- ce  in  1  a packer beat occurs this cycle.
- len  in  BIT_LEN  bits in this beat; legal values are 16, 32, 48, 64.
- pack_data  in  WIDTH  packer output register; valid one cycle after the beat.
- wr_data  out  WIDTH  word presented to DRAM.
- wr_addr  out  ADDR_W  word address of wr_data.
- wr_valid  out  1  wr_data/wr_addr are valid.
- wr_ready  in  1  DRAM accepts the word when wr_valid&wr_ready.
- fill  out  BIT_LEN  bits currently accumulated toward the next word (0..WIDTH-16).
- overflow  out  1  sticky: a captured word was dropped.
- len_err  out  1  sticky: ce was asserted with an illegal len.

Behaviour:
- Reset (rst_n=0, async):
  - fill=0, capture_pend=0, FIFO empty, wr_valid=0, wr_data=0, wr_addr=0, overflow=0, len_err=0.
  - Reset mid-operation discards all buffered words and the partial fill. It takes effect immediately, not at the next edge.
- Beat accounting, on each clk edge with ce=1:
  - Legal len: sum=fill+len (BIT_LEN+1 bits).
    - If sum>=WIDTH: fill<=sum-WIDTH and capture_pend<=1.
    - Else: fill<=sum and capture_pend<=0.
  - Illegal len (any value other than 16/32/48/64): fill unchanged, capture_pend<=0, len_err<=1.
- With ce=0: capture_pend<=0 and fill holds.
- Capture:
  - On the edge where capture_pend=1, pack_data is written to the FIFO tail together with the current address counter.
  - The address counter then increments, wrapping from ADDR_DEPTH-1 to 0.
  - Latency: beat edge N sets the flag, the word is captured at edge N+1, and wr_valid rises after edge N+1 if the FIFO was empty.
- FIFO: 2 entries, with registered head outputs wr_data, wr_addr and wr_valid.
  - Pop on wr_valid&wr_ready.
  - Push and pop on the same edge are both allowed at any occupancy, including full.
- Full boundary: a capture while the FIFO is full and no pop occurs on that edge:
  - the word is dropped;
  - the address counter still increments, so the DRAM address stays in step with the data stream;
  - overflow<=1.
- Empty boundary: wr_valid=0 and wr_data holds its last value; wr_ready is ignored.
- wr_data/wr_addr are stable while wr_valid=1 and wr_ready=0.
- Sticky flags overflow and len_err clear only on reset.

Optional Feature:
- Macro: DRAM_WR_DROP_CNT_EN.
- When defined:
  - adds output port drop_cnt[15:0], which counts dropped words and saturates at 16'hFFFF;
  - drop_cnt resets to 0.
- When undefined: the port and the counter are absent, and all other behaviour is identical.

Test Plan:
- Reset, then 17 beats with len=16, wr_ready=1 -> fill is 16,32,…,256, then 0 after beat 17. wr_valid=1 for exactly one cycle starting 2 cycles after beat 17, with wr_addr=0 and wr_data equal to pack_data at the capture edge.
- Beats with len=64 ×5 (sum 320) -> capture after beat 5 with fill=48. The next word completes after 4 more len=64 beats (48+256=304 -> fill=32); wr_addr=1.
- wr_ready=0 while 3 words complete -> words 0 and 1 are held with wr_addr stable, word 2 is dropped and overflow=1 (drop_cnt=1 with DRAM_WR_DROP_CNT_EN). Raising wr_ready then drains addresses 0 and 1, and the next word carries wr_addr=3.
- ce=1 with len=40 mid-stream -> len_err=1, fill unchanged, no capture. The following legal beats continue normally.
- With ADDR_DEPTH=4, capture 5 words with wr_ready=1 -> wr_addr sequence is 0,1,2,3,0.
- Assert rst_n=0 asynchronously while the FIFO holds 2 words and fill=128 -> wr_valid=0, fill=0, flags cleared immediately without waiting for a clock edge; after release, the first word gets wr_addr=0.
